// File: rtl/vga_bus_master_if.sv
// rtl/vga_bus_master_if.sv - command/response and device-bus bundle for vga_bus_master
interface vga_bus_master_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [3:0]                  cmd_address;
    logic [7:0]                  cmd_data;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [7:0]                  rsp_data;
    logic [3:0]                  bus_address;
    logic                        bus_enable;
    logic                        bus_mode;
    logic [7:0]                  bus_data_out;
    logic [7:0]                  bus_data_in;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_data, rsp_ready, bus_data_in,
        output cmd_ready, rsp_valid, rsp_data, bus_address, bus_enable, bus_mode,
               bus_data_out, fifo_count, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_data, rsp_ready, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_data, bus_address, bus_enable, bus_mode,
               bus_data_out, fifo_count, busy
    );
endinterface

// File: rtl/vga_bus_master.sv
// rtl/vga_bus_master.sv - queued register-access master driving a VGA device bus
module vga_bus_master #(
    parameter int FIFO_DEPTH  = 4,
    parameter int READ_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_bus_master_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = 2;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // FIFO entry layout: {write, address[3:0], data[7:0]}
    logic [12:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ready_en_q;
    logic          push;
    logic          pop;
    logic [12:0]   head;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_en_q, bus_en_d;
    logic          bus_mode_q, bus_mode_d;
    logic [3:0]    bus_addr_q, bus_addr_d;
    logic [7:0]    bus_dout_q, bus_dout_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    // ready_en_q holds cmd_ready low until the first edge after reset releases
    assign bus.cmd_ready = ready_en_q && (count_q < DEPTH_C);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_en_d    = bus_en_q;
        bus_mode_d  = bus_mode_q;
        bus_addr_d  = bus_addr_q;
        bus_dout_d  = bus_dout_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head[12]) begin
                        pop        = 1'b1;
                        bus_en_d   = 1'b1;
                        bus_mode_d = 1'b0;
                        bus_addr_d = head[11:8];
                        bus_dout_d = head[7:0];
                        state_d    = WRITE;
                    end else if (!rsp_valid_q) begin
                        // a read waits at the head until the previous response is taken
                        pop        = 1'b1;
                        bus_en_d   = 1'b1;
                        bus_mode_d = 1'b1;
                        bus_addr_d = head[11:8];
                        bus_dout_d = 8'h00;
                        cnt_d      = CW'(READ_CYCLES - 1);
                        state_d    = READ;
                    end
                end
            end
            WRITE: begin
                bus_en_d   = 1'b0;
                bus_mode_d = 1'b0;
                bus_addr_d = 4'h0;
                bus_dout_d = 8'h00;
                state_d    = IDLE;
            end
            READ: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = bus.bus_data_in;
                    rsp_valid_d = 1'b1;
                    bus_en_d    = 1'b0;
                    bus_mode_d  = 1'b0;
                    bus_addr_d  = 4'h0;
                    bus_dout_d  = 8'h00;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                bus_en_d   = 1'b0;
                bus_mode_d = 1'b0;
                bus_addr_d = 4'h0;
                bus_dout_d = 8'h00;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_address, bus.cmd_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_en_q    <= 1'b0;
            bus_mode_q  <= 1'b0;
            bus_addr_q  <= 4'h0;
            bus_dout_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_en_q  <= 1'b1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_en_q    <= bus_en_d;
            bus_mode_q  <= bus_mode_d;
            bus_addr_q  <= bus_addr_d;
            bus_dout_q  <= bus_dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.bus_enable   = bus_en_q;
    assign bus.bus_mode     = bus_mode_q;
    assign bus.bus_address  = bus_addr_q;
    assign bus.bus_data_out = bus_dout_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.fifo_count   = count_q;
    assign bus.busy         = (count_q != '0) || (state_q != IDLE) || rsp_valid_q;
endmodule
